// File: rtl/instr_loader_pkg.sv
// ----------------------------------------------------------------------------
// instr_loader_pkg
// Shared definitions for the IMEM instruction loader and its field encoder:
// data widths, instruction field bit positions (must stay in step with the
// instruction decoder), instruction format codes and loader state encodings.
// ----------------------------------------------------------------------------
package instr_loader_pkg;

    localparam int IMEM_DATA_WIDTH = 16;
    localparam int DMEM_DATA_WIDTH = 8;

    // Field placement inside an instruction word
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 4;
    localparam int REG_W      = 4;
    localparam int RD_LSB     = 4;
    localparam int RA_LSB     = 8;
    localparam int RB_LSB     = 12;
    localparam int IMM_LSB    = 8;

    // Instruction formats
    localparam logic FMT_R = 1'b0;
    localparam logic FMT_I = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
// Purely combinational packing of instruction fields into one IMEM word.
//   fmt     in  : FMT_R (rb/ra in the upper byte) or FMT_I (imm in upper byte)
//   opcode  in  : opcode field
//   rd      in  : destination register
//   ra, rb  in  : source registers, R-form only
//   imm     in  : immediate, I-form only
//   word    out : encoded instruction word
// ----------------------------------------------------------------------------
module instr_encoder
    import instr_loader_pkg::*;
(
    input  logic                       fmt,
    input  logic [OPCODE_W-1:0]        opcode,
    input  logic [REG_W-1:0]           rd,
    input  logic [REG_W-1:0]           ra,
    input  logic [REG_W-1:0]           rb,
    input  logic [DMEM_DATA_WIDTH-1:0] imm,
    output logic [IMEM_DATA_WIDTH-1:0] word
);

    // The upper byte is shared: either the two source registers or the
    // immediate, selected by the format bit.
    always_comb begin
        word = '0;
        word[OPCODE_LSB +: OPCODE_W] = opcode;
        word[RD_LSB +: REG_W]        = rd;
        if (fmt == FMT_I) begin
            word[IMM_LSB +: DMEM_DATA_WIDTH] = imm;
        end else begin
            word[RA_LSB +: REG_W] = ra;
            word[RB_LSB +: REG_W] = rb;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// ----------------------------------------------------------------------------
// instr_loader
// Accepts instruction field sets over a valid/ready stream, encodes each one
// and writes a programmed number of words to IMEM starting at a programmed
// base address (wrapping at the top of memory), then pulses done.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a load (sampled only when idle)
//   base_addr, length : first address / word count, captured on start
//   in_valid/in_ready : field-set handshake; in_ready high only while loading
//   in_fmt, in_opcode, in_rd, in_ra, in_rb, in_imm : instruction fields
//   imem_we/addr/wdata: registered IMEM write port, one cycle after acceptance
//   busy              : load in progress (LOAD or DONE)
//   done              : one-cycle pulse, coincident with the last write
//   checksum          : XOR of words written in the current load
//
// Build option: define INSTR_LOADER_CHECKSUM_EN to include the running
// checksum; otherwise checksum is tied to zero.
// ----------------------------------------------------------------------------
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [ADDR_WIDTH:0]        length,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_fmt,
    input  logic [OPCODE_W-1:0]        in_opcode,
    input  logic [REG_W-1:0]           in_rd,
    input  logic [REG_W-1:0]           in_ra,
    input  logic [REG_W-1:0]           in_rb,
    input  logic [DMEM_DATA_WIDTH-1:0] in_imm,
    output logic                       imem_we,
    output logic [ADDR_WIDTH-1:0]      imem_addr,
    output logic [IMEM_DATA_WIDTH-1:0] imem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic [IMEM_DATA_WIDTH-1:0] checksum
);

    state_t                     state;
    logic [ADDR_WIDTH-1:0]      cur_addr;
    logic [ADDR_WIDTH:0]        remaining;
    logic [IMEM_DATA_WIDTH-1:0] enc_word;
    logic                       accept;
    logic                       start_load;

    instr_encoder u_encoder (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .rd     (in_rd),
        .ra     (in_ra),
        .rb     (in_rb),
        .imm    (in_imm),
        .word   (enc_word)
    );

    // in_ready is only ever high in LOAD, so it alone qualifies acceptance.
    assign accept     = in_valid && in_ready;
    assign start_load = (state == ST_IDLE) && start;

    // Main sequencer. All outputs are registered; in_ready, busy and done
    // are set on the transition into the state that owns them so they line
    // up exactly with the state register. The address counter wraps
    // naturally at 2^ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_addr   <= '0;
            remaining  <= '0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr;
                        remaining <= length;
                        busy      <= 1'b1;
                        if (length == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= cur_addr;
                        imem_wdata <= enc_word;
                        cur_addr   <= cur_addr + ADDR_WIDTH'(1);
                        remaining  <= remaining - (ADDR_WIDTH+1)'(1);
                        if (remaining == (ADDR_WIDTH+1)'(1)) begin
                            state    <= ST_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Running XOR of written words; updated on the same edge that raises
    // imem_we, so it is final while done is high and holds until next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (start_load) begin
            checksum <= '0;
        end else if ((state == ST_LOAD) && accept) begin
            checksum <= checksum ^ enc_word;
        end
    end
`else
    logic unused_start_load;
    assign unused_start_load = start_load;
    assign checksum          = '0;
`endif

endmodule
